// File: rtl/regfile_pkg.sv
// Shared types for the register-file client: FSM states and the queued command record.
package regfile_pkg;

  localparam int REGFILE_WORDSIZE = 64;
  localparam int REGFILE_SIZE     = 32;
  localparam int REGFILE_ADDR_W   = $clog2(REGFILE_SIZE);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } regfile_state_e;

  typedef struct packed {
    logic                        write;
    logic [REGFILE_ADDR_W-1:0]   waddr;
    logic [REGFILE_WORDSIZE-1:0] wdata;
    logic [REGFILE_ADDR_W-1:0]   raddr_a;
    logic [REGFILE_ADDR_W-1:0]   raddr_b;
  } regfile_cmd_t;

  function automatic logic is_zero_addr(input logic [REGFILE_ADDR_W-1:0] addr);
    return addr == '0;
  endfunction

endpackage

// File: rtl/regfile_cmd_fifo.sv
// Synchronous command FIFO; pointers carry an extra wrap bit so full/empty come
// straight from a pointer compare.
module regfile_cmd_fifo
  import regfile_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  regfile_cmd_t push_data,
  input  logic         pop,
  output regfile_cmd_t head,
  output logic         full,
  output logic         empty
);

  localparam int IDX_W = $clog2(DEPTH);

  regfile_cmd_t     mem [DEPTH];
  logic [IDX_W:0]   wr_ptr_reg;
  logic [IDX_W:0]   rd_ptr_reg;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr_reg == rd_ptr_reg);
  assign full    = (wr_ptr_reg[IDX_W] != rd_ptr_reg[IDX_W]) &&
                   (wr_ptr_reg[IDX_W-1:0] == rd_ptr_reg[IDX_W-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr_reg[IDX_W-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr_reg[IDX_W-1:0]] <= push_data;
        wr_ptr_reg <= wr_ptr_reg + (IDX_W+1)'(1);
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + (IDX_W+1)'(1);
      end
    end
  end

endmodule

// File: rtl/regfile_client.sv
// Initiator for the register_file ports: queues commands and executes them strictly in order.
// Optional REGFILE_CLIENT_X0_ZERO_EN makes address 0 a hardwired zero register.
module regfile_client
  import regfile_pkg::*;
#(
  parameter int WORDSIZE  = REGFILE_WORDSIZE,
  parameter int SIZE      = REGFILE_SIZE,
  parameter int ADDR_W    = $clog2(SIZE),
  parameter int CMD_DEPTH = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_write,
  input  logic [ADDR_W-1:0]   cmd_waddr,
  input  logic [WORDSIZE-1:0] cmd_wdata,
  input  logic [ADDR_W-1:0]   cmd_raddr_a,
  input  logic [ADDR_W-1:0]   cmd_raddr_b,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [WORDSIZE-1:0] rsp_data_a,
  output logic [WORDSIZE-1:0] rsp_data_b,
  output logic                write_en,
  output logic [ADDR_W-1:0]   write_addr,
  output logic [WORDSIZE-1:0] write_data,
  output logic [ADDR_W-1:0]   addr_a,
  input  logic [WORDSIZE-1:0] data_a,
  output logic [ADDR_W-1:0]   addr_b,
  input  logic [WORDSIZE-1:0] data_b,
  output logic                busy
);

  regfile_state_e      state_reg, state_next;
  regfile_cmd_t        cmd_in;
  regfile_cmd_t        fifo_head;
  logic                fifo_full, fifo_empty, fifo_pop, fifo_push;

  logic                op_write_reg;
  logic [ADDR_W-1:0]   waddr_reg, raddr_a_reg, raddr_b_reg;
  logic [WORDSIZE-1:0] wdata_reg;
  logic                rsp_valid_reg;
  logic [WORDSIZE-1:0] rsp_a_reg, rsp_b_reg;
  logic                waddr_zero, raddr_a_zero, raddr_b_zero;

  always_comb begin
    cmd_in         = '0;
    cmd_in.write   = cmd_write;
    cmd_in.waddr   = cmd_waddr;
    cmd_in.wdata   = cmd_wdata;
    cmd_in.raddr_a = cmd_raddr_a;
    cmd_in.raddr_b = cmd_raddr_b;
  end

  // Reset gates ready combinationally so nothing is accepted on the reset edge.
  assign cmd_ready = !fifo_full && !reset;
  assign fifo_push = cmd_valid && cmd_ready;

  regfile_cmd_fifo #(
    .DEPTH(CMD_DEPTH)
  ) u_cmd_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (fifo_push),
    .push_data(cmd_in),
    .pop      (fifo_pop),
    .head     (fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

`ifdef REGFILE_CLIENT_X0_ZERO_EN
  assign waddr_zero   = is_zero_addr(waddr_reg);
  assign raddr_a_zero = is_zero_addr(raddr_a_reg);
  assign raddr_b_zero = is_zero_addr(raddr_b_reg);
`else
  assign waddr_zero   = 1'b0;
  assign raddr_a_zero = 1'b0;
  assign raddr_b_zero = 1'b0;
`endif

  always_comb begin
    state_next = state_reg;
    fifo_pop   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          state_next = EXEC;
        end
      end
      EXEC:    state_next = op_write_reg ? IDLE : RESP;
      RESP:    if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Write and read fields load separately so unused ports keep their last value.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      op_write_reg  <= 1'b0;
      waddr_reg     <= '0;
      wdata_reg     <= '0;
      raddr_a_reg   <= '0;
      raddr_b_reg   <= '0;
      rsp_valid_reg <= 1'b0;
      rsp_a_reg     <= '0;
      rsp_b_reg     <= '0;
    end else begin
      state_reg <= state_next;
      if (fifo_pop) begin
        op_write_reg <= fifo_head.write;
        if (fifo_head.write) begin
          waddr_reg <= fifo_head.waddr;
          wdata_reg <= fifo_head.wdata;
        end else begin
          raddr_a_reg <= fifo_head.raddr_a;
          raddr_b_reg <= fifo_head.raddr_b;
        end
      end
      if (state_reg == EXEC && !op_write_reg) begin
        rsp_valid_reg <= 1'b1;
        rsp_a_reg     <= raddr_a_zero ? '0 : data_a;
        rsp_b_reg     <= raddr_b_zero ? '0 : data_b;
      end else if (state_reg == RESP && rsp_ready) begin
        rsp_valid_reg <= 1'b0;
      end
    end
  end

  assign write_en   = (state_reg == EXEC) && op_write_reg && !waddr_zero;
  assign write_addr = waddr_reg;
  assign write_data = wdata_reg;
  assign addr_a     = raddr_a_reg;
  assign addr_b     = raddr_b_reg;
  assign rsp_valid  = rsp_valid_reg;
  assign rsp_data_a = rsp_a_reg;
  assign rsp_data_b = rsp_b_reg;
  assign busy       = !fifo_empty || (state_reg != IDLE);

endmodule

// File: tb/tb_regfile_client.sv
// Directed bench for regfile_client with a behavioural register file attached.
// Honours REGFILE_CLIENT_X0_ZERO_EN for the address-0 expectations.
module tb_regfile_client;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [4:0]  cmd_waddr, cmd_raddr_a, cmd_raddr_b;
  logic [63:0] cmd_wdata;
  logic        rsp_valid, rsp_ready;
  logic [63:0] rsp_data_a, rsp_data_b;
  logic        write_en;
  logic [4:0]  write_addr, addr_a, addr_b;
  logic [63:0] write_data, data_a, data_b;
  logic        busy;

  logic [63:0] rf [32];
  int          we_count = 0;
  int          total = 0;
  int          bad = 0;

  regfile_client dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_waddr(cmd_waddr), .cmd_wdata(cmd_wdata),
    .cmd_raddr_a(cmd_raddr_a), .cmd_raddr_b(cmd_raddr_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data_a(rsp_data_a), .rsp_data_b(rsp_data_b),
    .write_en(write_en), .write_addr(write_addr), .write_data(write_data),
    .addr_a(addr_a), .data_a(data_a), .addr_b(addr_b), .data_b(data_b),
    .busy(busy)
  );

  always #5 clk = ~clk;

  assign data_a = rf[addr_a];
  assign data_b = rf[addr_b];

  always @(posedge clk) begin
    if (write_en) begin
      rf[write_addr] <= write_data;
      we_count <= we_count + 1;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_cmd(input logic w, input logic [4:0] wa, input logic [63:0] wd,
                          input logic [4:0] ra, input logic [4:0] rb);
    int n = 0;
    cmd_write = w; cmd_waddr = wa; cmd_wdata = wd;
    cmd_raddr_a = ra; cmd_raddr_b = rb; cmd_valid = 1'b1;
    while (!cmd_ready && n < 100) begin
      step();
      n++;
    end
    if (n >= 100) check("push_timeout", 64'd0, 64'd1);
    step();
    cmd_valid = 1'b0;
    $display("push write=%0d waddr=%0d wdata=%h raddr_a=%0d raddr_b=%0d", w, wa, wd, ra, rb);
  endtask

  task automatic take_rsp(input string tag, input logic [63:0] ea, input logic [63:0] eb);
    int n = 0;
    while (!rsp_valid && n < 100) begin
      step();
      n++;
    end
    check({tag, "_valid"}, {63'd0, rsp_valid}, 64'd1);
    check({tag, "_a"}, rsp_data_a, ea);
    check({tag, "_b"}, rsp_data_b, eb);
    $display("rsp %s a=%h b=%h", tag, rsp_data_a, rsp_data_b);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
  endtask

  initial begin
    int we_snap;
    int n;
    for (int i = 0; i < 32; i++) rf[i] = 64'hA5A5_0000_0000_0000 | 64'(i);
    reset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_waddr = '0;
    cmd_wdata = '0; cmd_raddr_a = '0; cmd_raddr_b = '0; rsp_ready = 1'b0;

    // Reset state
    repeat (3) step();
    check("rst_cmd_ready", {63'd0, cmd_ready}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    check("rst_write_en", {63'd0, write_en}, 64'd0);
    check("rst_write_addr", {59'd0, write_addr}, 64'd0);
    check("rst_rsp_a", rsp_data_a, 64'd0);
    reset = 1'b0;
    #0;
    check("post_rst_ready", {63'd0, cmd_ready}, 64'd1);

    // Write r5 with latency checks, then dual read 5/6
    we_snap = we_count;
    push_cmd(1'b1, 5'd5, 64'hDEAD_BEEF_0000_0001, 5'd0, 5'd0);
    check("wr_idle_we", {63'd0, write_en}, 64'd0);
    check("wr_idle_busy", {63'd0, busy}, 64'd1);
    step();
    check("wr_exec_we", {63'd0, write_en}, 64'd1);
    check("wr_exec_addr", {59'd0, write_addr}, 64'd5);
    check("wr_exec_data", write_data, 64'hDEAD_BEEF_0000_0001);
    step();
    check("wr_done_we", {63'd0, write_en}, 64'd0);
    check("wr_done_busy", {63'd0, busy}, 64'd0);
    check("wr_pulses", 64'(we_count - we_snap), 64'd1);
    push_cmd(1'b0, 5'd0, 64'd0, 5'd5, 5'd6);
    step();
    check("rd_exec_addr_a", {59'd0, addr_a}, 64'd5);
    check("rd_exec_addr_b", {59'd0, addr_b}, 64'd6);
    check("rd_exec_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    check("rd_exec_we", {63'd0, write_en}, 64'd0);
    step();
    check("rd_hold_waddr", {59'd0, write_addr}, 64'd5);
    take_rsp("rd56", 64'hDEAD_BEEF_0000_0001, 64'hA5A5_0000_0000_0006);
    check("rd56_released", {63'd0, rsp_valid}, 64'd0);
    check("rd56_held_a", rsp_data_a, 64'hDEAD_BEEF_0000_0001);

    // Backpressure: one read parks in RESP, four more fill the FIFO
    push_cmd(1'b0, 5'd0, 64'd0, 5'd1, 5'd2);
    push_cmd(1'b0, 5'd0, 64'd0, 5'd3, 5'd4);
    push_cmd(1'b0, 5'd0, 64'd0, 5'd7, 5'd8);
    push_cmd(1'b0, 5'd0, 64'd0, 5'd9, 5'd10);
    push_cmd(1'b0, 5'd0, 64'd0, 5'd11, 5'd12);
    cmd_valid = 1'b1; cmd_raddr_a = 5'd13; cmd_raddr_b = 5'd14;
    for (int k = 0; k < 3; k++) begin
      check("full_ready", {63'd0, cmd_ready}, 64'd0);
      check("full_rsp_a", rsp_data_a, 64'hA5A5_0000_0000_0001);
      check("full_rsp_valid", {63'd0, rsp_valid}, 64'd1);
      step();
    end
    cmd_valid = 1'b0;
    take_rsp("bp0", 64'hA5A5_0000_0000_0001, 64'hA5A5_0000_0000_0002);
    take_rsp("bp1", 64'hA5A5_0000_0000_0003, 64'hA5A5_0000_0000_0004);
    take_rsp("bp2", 64'hA5A5_0000_0000_0007, 64'hA5A5_0000_0000_0008);
    take_rsp("bp3", 64'hA5A5_0000_0000_0009, 64'hA5A5_0000_0000_000A);
    take_rsp("bp4", 64'hA5A5_0000_0000_000B, 64'hA5A5_0000_0000_000C);
    step();
    check("bp_idle_busy", {63'd0, busy}, 64'd0);

    // Read-after-write ordering through the queue
    push_cmd(1'b1, 5'd3, 64'h11, 5'd0, 5'd0);
    push_cmd(1'b0, 5'd0, 64'd0, 5'd3, 5'd3);
    push_cmd(1'b1, 5'd3, 64'h22, 5'd0, 5'd0);
    push_cmd(1'b0, 5'd0, 64'd0, 5'd3, 5'd5);
    take_rsp("raw1", 64'h11, 64'h11);
    take_rsp("raw2", 64'h22, 64'hDEAD_BEEF_0000_0001);

    // Reset while a read is in EXEC with two writes still queued
    push_cmd(1'b0, 5'd0, 64'd0, 5'd1, 5'd2);
    push_cmd(1'b0, 5'd0, 64'd0, 5'd3, 5'd4);
    push_cmd(1'b1, 5'd9, 64'h99, 5'd0, 5'd0);
    push_cmd(1'b1, 5'd10, 64'hAA, 5'd0, 5'd0);
    n = 0;
    while (!rsp_valid && n < 100) begin
      step();
      n++;
    end
    check("rr_first_a", rsp_data_a, 64'hA5A5_0000_0000_0001);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    step();
    check("rr_exec_addr_a", {59'd0, addr_a}, 64'd3);
    reset = 1'b1;
    step();
    check("rr_we", {63'd0, write_en}, 64'd0);
    check("rr_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    check("rr_rsp_a", rsp_data_a, 64'd0);
    check("rr_addr_a", {59'd0, addr_a}, 64'd0);
    check("rr_write_data", write_data, 64'd0);
    check("rr_busy", {63'd0, busy}, 64'd0);
    check("rr_cmd_ready", {63'd0, cmd_ready}, 64'd0);
    reset = 1'b0;
    we_snap = we_count;
    repeat (8) step();
    check("rr_no_writes", 64'(we_count - we_snap), 64'd0);
    check("rr_busy_after", {63'd0, busy}, 64'd0);
    check("rr_r9_intact", rf[9], 64'hA5A5_0000_0000_0009);

    // Address 0 behaviour
    we_snap = we_count;
    push_cmd(1'b1, 5'd0, 64'hFF, 5'd0, 5'd0);
    push_cmd(1'b0, 5'd0, 64'd0, 5'd0, 5'd0);
`ifdef REGFILE_CLIENT_X0_ZERO_EN
    take_rsp("x0", 64'd0, 64'd0);
    check("x0_pulses", 64'(we_count - we_snap), 64'd0);
`else
    take_rsp("x0", 64'hFF, 64'hFF);
    check("x0_pulses", 64'(we_count - we_snap), 64'd1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
